// File: rtl/cell_plotter_pkg.sv
// Shared definitions for the grid-cell display path: plotter state encoding,
// colour constants and the cell geometry that the coordinate translator also uses.
package cell_plotter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } plot_state_e;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // Cells sit on an 11x8 pitch, so a 10x7 box leaves a 1-pixel gap between neighbours.
  localparam int CELL_PITCH_X  = 11;
  localparam int CELL_PITCH_Y  = 8;
  localparam int CELL_ORIGIN_X = 28;
  localparam int CELL_ORIGIN_Y = 30;
  localparam int CELL_BOX_W    = 10;
  localparam int CELL_BOX_H    = 7;
  localparam int SCREEN_W_DEF  = 160;
  localparam int SCREEN_H_DEF  = 120;

  function automatic logic on_border(input logic [7:0] dx, input logic [7:0] dy,
                                     input logic [7:0] w_last, input logic [7:0] h_last);
    return (dx == 8'd0) || (dx == w_last) || (dy == 8'd0) || (dy == h_last);
  endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// Request/pixel bundle between the cell-coordinate translator (master) and the
// plotter (slave); the pixel side feeds the VGA adapter write port.
interface cell_plotter_if;
  import cell_plotter_pkg::*;

  // start/clear are level requests, sampled only on an edge where the plotter is
  // IDLE (busy=0); anything asserted while busy=1 is dropped, never queued.
  logic        start;
  logic        clear;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [2:0]  colour_in;
  logic        draw_full;
  logic [7:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        done;
  plot_state_e dbg_state;

  modport master (
    output start, clear, x_in, y_in, colour_in, draw_full,
    input  vga_x, vga_y, vga_colour, plot, busy, done, dbg_state
  );

  modport slave (
    input  start, clear, x_in, y_in, colour_in, draw_full,
    output vga_x, vga_y, vga_colour, plot, busy, done, dbg_state
  );
endinterface

// File: rtl/cell_plotter_raster_counter.sv
// 2-D raster offset counter: dx runs fastest, dy steps when dx wraps at its limit.
// Exposes the next values so the owner can register outputs in step with the count.
module cell_plotter_raster_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [7:0] w_last_i,
  input  logic [7:0] h_last_i,
  output logic [7:0] dx_o,
  output logic [7:0] dy_o,
  output logic [7:0] dx_next_o,
  output logic [7:0] dy_next_o,
  output logic       last_o
);
  logic [7:0] dx_q, dx_d, dy_q, dy_d;
  logic [7:0] w_last_q, w_last_d, h_last_q, h_last_d;

  always_comb begin
    dx_d     = dx_q;
    dy_d     = dy_q;
    w_last_d = w_last_q;
    h_last_d = h_last_q;
    if (load_i) begin
      dx_d     = 8'd0;
      dy_d     = 8'd0;
      w_last_d = w_last_i;
      h_last_d = h_last_i;
    end else if (en_i) begin
      if (dx_q == w_last_q) begin
        dx_d = 8'd0;
        dy_d = dy_q + 8'd1;
      end else begin
        dx_d = dx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx_q     <= 8'd0;
      dy_q     <= 8'd0;
      w_last_q <= 8'd0;
      h_last_q <= 8'd0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      w_last_q <= w_last_d;
      h_last_q <= h_last_d;
    end
  end

  assign dx_o      = dx_q;
  assign dy_o      = dy_q;
  assign dx_next_o = dx_d;
  assign dy_next_o = dy_d;
  assign last_o    = (dx_q == w_last_q) && (dy_q == h_last_q);
endmodule

// File: rtl/cell_plotter.sv
// Rasterises one cell request (or a full-screen clear) into per-pixel VGA writes,
// one pixel per clock, with every output registered.
module cell_plotter
  import cell_plotter_pkg::*;
#(
  parameter int BOX_W    = CELL_BOX_W,
  parameter int BOX_H    = CELL_BOX_H,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clock,
  input  logic           reset,
  cell_plotter_if.slave  bus
);
  localparam logic [7:0] BOX_W_LAST = 8'(BOX_W - 1);
  localparam logic [7:0] BOX_H_LAST = 8'(BOX_H - 1);
  localparam logic [7:0] SCR_W_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] SCR_H_LAST = 8'(SCREEN_H - 1);

  plot_state_e state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d;
  logic [2:0]  col_q, col_d;
  logic        full_q, full_d;
  logic [7:0]  vga_x_q, vga_x_d, vga_y_q, vga_y_d;
  logic [2:0]  vga_col_q, vga_col_d;
  logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic        cnt_load, cnt_en, cnt_last;
  logic [7:0]  w_last_sel, h_last_sel;
  logic [7:0]  dx, dy, dx_next, dy_next;

  cell_plotter_raster_counter u_raster (
    .clock     (clock),
    .reset     (reset),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .w_last_i  (w_last_sel),
    .h_last_i  (h_last_sel),
    .dx_o      (dx),
    .dy_o      (dy),
    .dx_next_o (dx_next),
    .dy_next_o (dy_next),
    .last_o    (cnt_last)
  );

  // Next-state: the counter holds the offsets of the pixel currently on the outputs.
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    w_last_sel = BOX_W_LAST;
    h_last_sel = BOX_H_LAST;
    x0_d       = x0_q;
    y0_d       = y0_q;
    col_d      = col_q;
    full_d     = full_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          state_d    = ST_CLEAR;
          cnt_load   = 1'b1;
          w_last_sel = SCR_W_LAST;
          h_last_sel = SCR_H_LAST;
        end else if (bus.start) begin
          state_d  = ST_DRAW;
          cnt_load = 1'b1;
          x0_d     = bus.x_in;
          y0_d     = bus.y_in;
          col_d    = bus.colour_in;
          full_d   = bus.draw_full;
        end
      end
      ST_DRAW, ST_CLEAR: begin
        if (cnt_last) state_d = ST_DONE;
        else          cnt_en  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so pixel 0 appears right after the request edge.
  always_comb begin
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    case (state_d)
      ST_DRAW: begin
        vga_x_d   = x0_d + dx_next;
        vga_y_d   = y0_d + dy_next;
        vga_col_d = col_d;
        plot_d    = full_d || on_border(dx_next, dy_next, BOX_W_LAST, BOX_H_LAST);
      end
      ST_CLEAR: begin
        vga_x_d   = dx_next;
        vga_y_d   = dy_next;
        vga_col_d = COLOUR_BLACK;
        plot_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x0_q      <= 8'd0;
      y0_q      <= 8'd0;
      col_q     <= 3'd0;
      full_q    <= 1'b0;
      vga_x_q   <= 8'd0;
      vga_y_q   <= 8'd0;
      vga_col_q <= 3'd0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      col_q     <= col_d;
      full_q    <= full_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_col_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;

  // dx/dy are observed only through the next-value path.
  logic unused_cnt;
  assign unused_cnt = ^{dx, dy};
endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: drivers issue cell/clear requests, a reference model
// pushes the per-cycle expected outputs, and a monitor compares them every cycle.
module tb_cell_plotter;
  import cell_plotter_pkg::*;

  localparam int BW = 10;
  localparam int BH = 7;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int VW = 22;

  logic clock = 1'b0;
  logic reset = 1'b1;
  cell_plotter_if bus();

  cell_plotter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [VW-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int plot_cnt = 0;
  bit mon_en   = 1'b0;

  function automatic logic [VW-1:0] pack(input logic b, input logic d, input logic p,
                                         input logic [2:0] c, input logic [7:0] x,
                                         input logic [7:0] y);
    return {b, d, p, c, x, y};
  endfunction

  // Reference model: every box position in raster order, then one DONE cycle.
  task automatic model_draw(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [2:0] c, input logic full);
    logic edge_px;
    for (int r = 0; r < BH; r++) begin
      for (int k = 0; k < BW; k++) begin
        edge_px = (r == 0) || (r == BH - 1) || (k == 0) || (k == BW - 1);
        exp_q.push_back(pack(1'b1, 1'b0, full || edge_px, c,
                             8'((int'(x0) + k) % 256), 8'((int'(y0) + r) % 256)));
      end
    end
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, c,
                         8'((int'(x0) + BW - 1) % 256), 8'((int'(y0) + BH - 1) % 256)));
  endtask

  task automatic model_clear();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 3'b000, 8'(x), 8'(y)));
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 3'b000, 8'(SW - 1), 8'(SH - 1)));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  // Monitor: one expected vector per cycle while a sweep is outstanding, quiet outputs otherwise.
  always @(negedge clock) begin
    logic [VW-1:0] got, need;
    if (mon_en) begin
      got = pack(bus.busy, bus.done, bus.plot, bus.vga_colour, bus.vga_x, bus.vga_y);
      checks++;
      if (exp_q.size() > 0) begin
        need = exp_q.pop_front();
        if (got !== need) begin
          errors++;
          $display("FAIL pixel_stream t=%0t got busy=%b done=%b plot=%b col=%b x=%0d y=%0d need busy=%b done=%b plot=%b col=%b x=%0d y=%0d",
                   $time, got[21], got[20], got[19], got[18:16], got[15:8], got[7:0],
                   need[21], need[20], need[19], need[18:16], need[15:8], need[7:0]);
        end
      end else if ({bus.busy, bus.done, bus.plot} !== 3'b000) begin
        errors++;
        $display("FAIL idle_outputs t=%0t got busy=%b done=%b plot=%b need 000",
                 $time, bus.busy, bus.done, bus.plot);
      end
      if (bus.plot === 1'b1) plot_cnt++;
    end
  end

  task automatic request(input logic clr, input logic st, input logic [7:0] x,
                         input logic [7:0] y, input logic [2:0] c, input logic full);
    @(negedge clock);
    bus.clear     = clr;
    bus.start     = st;
    bus.x_in      = x;
    bus.y_in      = y;
    bus.colour_in = c;
    bus.draw_full = full;
    @(posedge clock);
    if (clr)     model_clear();
    else if (st) model_draw(x, y, c, full);
    #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [2:0] rc;
    logic       rf;
    bus.start = 1'b0; bus.clear = 1'b0; bus.x_in = 8'd0; bus.y_in = 8'd0;
    bus.colour_in = 3'd0; bus.draw_full = 1'b0;

    #2 reset = 1'b0;
    #20;
    check("reset_vga_x", 32'(bus.vga_x), 32'd0);
    check("reset_vga_y", 32'(bus.vga_y), 32'd0);
    check("reset_colour", 32'(bus.vga_colour), 32'd0);
    check("reset_plot_busy_done", 32'({bus.plot, bus.busy, bus.done}), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;

    plot_cnt = 0;
    request(1'b0, 1'b1, 8'd28, 8'd30, COLOUR_RED, 1'b1);
    wait_drain(500);
    check("filled_plot_count", 32'(plot_cnt), 32'd70);

    plot_cnt = 0;
    request(1'b0, 1'b1, 8'd39, 8'd38, COLOUR_WHITE, 1'b0);
    wait_drain(500);
    check("outline_plot_count", 32'(plot_cnt), 32'd30);

    plot_cnt = 0;
    request(1'b1, 1'b1, 8'd12, 8'd14, COLOUR_WHITE, 1'b1);
    wait_drain(25000);
    check("clear_plot_count", 32'(plot_cnt), 32'(SW * SH));

    // A second start mid-draw must not disturb the sweep; the next one after DONE must run.
    request(1'b0, 1'b1, 8'd100, 8'd50, 3'b010, 1'b1);
    repeat (20) @(posedge clock);
    bus.start = 1'b1;
    bus.x_in  = 8'd5;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_drain(500);
    request(1'b0, 1'b1, 8'd61, 8'd22, 3'b001, 1'b0);
    wait_drain(500);

    request(1'b0, 1'b1, 8'd250, 8'd253, 3'b011, 1'b1);
    wait_drain(500);

    for (int i = 0; i < 8; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 3'($urandom_range(0, 7));
      rf = 1'($urandom_range(0, 1));
      request(1'b0, 1'b1, rx, ry, rc, rf);
      wait_drain(500);
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end

    request(1'b0, 1'b1, 8'd60, 8'd70, 3'b101, 1'b1);
    repeat (35) @(posedge clock);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_reset_plot", 32'(bus.plot), 32'd0);
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    check("async_reset_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge clock);
    request(1'b0, 1'b1, 8'd60, 8'd70, 3'b110, 1'b0);
    wait_drain(500);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cell_plotter.md
Name: cell_plotter

Overview:
- Consumer end of the grid-cell interface: takes one cell request (origin X/Y, colour, fill mode) and rasterises it into per-pixel VGA framebuffer writes, one pixel per clock.
- Also provides a full-screen clear sweep.
- Sits between the cell-coordinate translator and the VGA adapter's x/y/colour/plot write port.

Parameters:
- BOX_W, 10, cell width in pixels (cell pitch 11 leaves a 1-pixel gap).
- BOX_H, 7, cell height in pixels (cell pitch 8).
- SCREEN_W, 160, framebuffer width for clear.
- SCREEN_H, 120, framebuffer height for clear.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  request: draw a cell at x_in/y_in; sampled only in IDLE.
- clear  in  1  request: fill the whole screen with colour 000; sampled only in IDLE.
- x_in  in  8  cell origin X (top-left).
- y_in  in  8  cell origin Y (top-left).
- colour_in  in  3  RGB colour for the cell.
- draw_full  in  1  1 = filled box; 0 = 1-pixel outline only.
- vga_x  out  8  pixel X to the framebuffer.
- vga_y  out  8  pixel Y to the framebuffer.
- vga_colour  out  3  pixel colour.
- plot  out  1  write enable for the current vga_x/vga_y/vga_colour.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- States: IDLE, DRAW, CLEAR, DONE. All outputs are registered.
- Reset (asynchronous, any state, mid-operation included):
  - state goes to IDLE; all outputs and internal counters go to 0.
  - Any in-progress sweep is abandoned with no done pulse.
- IDLE:
  - clear=1 at a clock edge: go to CLEAR. clear has priority over a simultaneous start.
  - Else start=1: latch x_in, y_in, colour_in and draw_full, then go to DRAW.
  - Inputs are ignored in every other state; requests are not queued.
- DRAW:
  - Offsets dx and dy start at 0, in raster order: dx increments first; at dx=BOX_W-1, dx wraps to 0 and dy increments.
  - Each cycle outputs vga_x=x0+dx and vga_y=y0+dy. Arithmetic is 8-bit modulo 256, with no clipping.
  - vga_colour = latched colour.
  - plot=1 if latched draw_full=1, or if the pixel is on the border (dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1); otherwise plot=0.
  - Every pixel position is visited regardless of mode, so latency is fixed.
  - After (BOX_W-1, BOX_H-1), go to DONE.
- CLEAR:
  - Same raster sweep over x=0..SCREEN_W-1 and y=0..SCREEN_H-1.
  - vga_colour=000, plot=1 on every cycle.
  - After (SCREEN_W-1, SCREEN_H-1), go to DONE.
- DONE: done=1 and plot=0 for exactly one cycle, then IDLE.
- Timing, with the request sampled at edge k:
  - Pixel i (0-based) is valid in cycle k+1+i.
  - done is high in cycle k+N+1, where N = BOX_W*BOX_H (draw) or SCREEN_W*SCREEN_H (clear).
  - busy is high in cycles k+1 through k+N+1 inclusive.
  - A new request is accepted at the edge that ends the DONE cycle plus one, i.e. in IDLE.
- Outside DRAW and CLEAR: plot=0; vga_x, vga_y and vga_colour hold their last values.
- Counters:
  - dx/dy counters are 8 bits wide (enough for SCREEN_W/SCREEN_H).
  - Terminal compares use the parameter minus 1.

Decomposition:
- Shared package:
  - State encoding enum.
  - Colour constants: BLACK=000, RED=100, WHITE=111.
  - Cell geometry constants: pitch 11/8, origin offsets 28/30, BOX_W/BOX_H defaults.
  - The translator and this block import the same geometry constants.
- One sub-module is natural: raster_counter. It is a 2-D dx/dy counter with load, enable, programmable width/height limits and a last flag; DRAW and CLEAR reuse it.

Test Plan:
- Filled cell, colour 100:
  - Stimulus: start with x_in=28, y_in=30, colour_in=100, draw_full=1.
  - Response: 70 consecutive plot=1 cycles; first pixel (28,30), 11th pixel (28,31), last pixel (37,36); done one cycle later; busy for 71 cycles.
- Outline cell, colour 111:
  - Stimulus: start with x_in=39, y_in=38, colour_in=111, draw_full=0.
  - Response: 70 sweep cycles with exactly 30 plot=1; pixel (40,39) has plot=0; pixels (39,38) and (48,44) have plot=1.
- Clear, with simultaneous start:
  - Stimulus: clear=1 and start=1 in the same cycle.
  - Response: CLEAR runs, not DRAW; 19200 plot cycles with colour 000; first pixel (0,0), last pixel (159,119); done at cycle k+19201.
- Busy lockout:
  - Stimulus: start pulsed again at draw pixel 20 with different x_in.
  - Response: ignored; output sequence and done timing unchanged; a start in the cycle after done begins a new draw.
- Wrap:
  - Stimulus: x_in=250, y_in=253, full.
  - Response: vga_x sequence 250..255, 0..3; last pixel (3,3).
- Reset mid-draw:
  - Stimulus: reset low at pixel 35.
  - Response: plot, busy and done go to 0 immediately, without waiting for a clock edge; no done pulse; after release, start works normally from (x_in, y_in).
